// File: rtl/compare_arbiter.sv
// compare_arbiter: round-robin sharing of one comparator between two requesters,
// holding registered operands for SETTLE cycles before returning the result.
module compare_arbiter #(
  parameter int WIDTH     = 8,
  parameter int RES_WIDTH = 8,
  parameter int SETTLE    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  output logic                 gnt0,
  output logic                 done0,
  output logic [RES_WIDTH-1:0] result0,
  input  logic                 req1,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic                 gnt1,
  output logic                 done1,
  output logic [RES_WIDTH-1:0] result1,
  output logic [WIDTH-1:0]     comparator_input1,
  output logic [WIDTH-1:0]     comparator_input2,
  input  logic [RES_WIDTH-1:0] cmp_out,
  output logic                 busy
);
  typedef enum logic {IDLE, SETTLING} state_t;
  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 last_q, last_d;
  logic                 port_q, port_d;
  logic                 gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                 done0_q, done0_d, done1_q, done1_d;
  logic [WIDTH-1:0]     ci1_q, ci1_d, ci2_q, ci2_d;
  logic [RES_WIDTH-1:0] res0_q, res0_d, res1_q, res1_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    port_d  = port_q;
    ci1_d   = ci1_q;
    ci2_d   = ci2_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    if (state_q == IDLE) begin
      if (req0 | req1) begin
        // on a tie the port that did not win last time goes first
        port_d  = (req0 & req1) ? ~last_q : req1;
        ci1_d   = port_d ? a1 : a0;
        ci2_d   = port_d ? b1 : b0;
        gnt0_d  = ~port_d;
        gnt1_d  = port_d;
        last_d  = port_d;
        cnt_d   = 4'(SETTLE - 1);
        state_d = SETTLING;
      end
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      res0_d  = port_q ? res0_q : cmp_out;
      res1_d  = port_q ? cmp_out : res1_q;
      done0_d = ~port_q;
      done1_d = port_q;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      ci1_q   <= '0;
      ci2_q   <= '0;
      res0_q  <= '0;
      res1_q  <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      port_q  <= port_d;
      ci1_q   <= ci1_d;
      ci2_q   <= ci2_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end
  assign gnt0              = gnt0_q;
  assign gnt1              = gnt1_q;
  assign done0             = done0_q;
  assign done1             = done1_q;
  assign result0           = res0_q;
  assign result1           = res1_q;
  assign comparator_input1 = ci1_q;
  assign comparator_input2 = ci2_q;
  assign busy              = (state_q == SETTLING);
endmodule

// File: tb/tb_compare_arbiter.sv
// tb_compare_arbiter: random and directed traffic scored against a deadline-based
// transaction model; a negedge monitor pops expected gnt/done events.
module tb_compare_arbiter;
  localparam int SETTLE = 3;
  logic       clk = 1'b0, reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0, cmp_out = '0;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [7:0] result0, result1, ci1, ci2;
  always #5 clk = ~clk;
  compare_arbiter #(.WIDTH(8), .RES_WIDTH(8), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0), .done0(done0), .result0(result0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1), .done1(done1), .result1(result1),
    .comparator_input1(ci1), .comparator_input2(ci2), .cmp_out(cmp_out), .busy(busy)
  );
  int n_chk = 0, n_pass = 0;
  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask
  // s bits: {done1, done0, gnt1, gnt0}
  typedef struct {int cyc; logic [3:0] s; logic [7:0] v1; logic [7:0] v2;} ev_t;
  ev_t sb[$];
  int  glog[$];
  int  cyc = 0, m_done_at = 0;
  bit  m_on = 0, m_idle = 1, m_last = 1, m_port = 0;
  logic [7:0] m_ci1 = '0, m_ci2 = '0, m_res0 = '0, m_res1 = '0;
  // reference: a grant books the comparator until an absolute deadline cycle
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_on = 1; m_idle = 1; m_last = 1;
      m_ci1 = '0; m_ci2 = '0; m_res0 = '0; m_res1 = '0;
    end else if (m_on) begin
      if (!m_idle) begin
        if (cyc == m_done_at) begin
          if (m_port) m_res1 = cmp_out; else m_res0 = cmp_out;
          sb.push_back('{cyc, m_port ? 4'b1000 : 4'b0100, cmp_out, 8'h00});
          m_idle = 1;
        end
      end else if (req0 || req1) begin
        m_port = (req0 && req1) ? !m_last : req1;
        m_ci1 = m_port ? a1 : a0;
        m_ci2 = m_port ? b1 : b0;
        sb.push_back('{cyc, m_port ? 4'b0010 : 4'b0001, m_ci1, m_ci2});
        m_last = m_port; m_idle = 0; m_done_at = cyc + SETTLE;
      end
    end
  end
  logic [3:0] mon_es, mon_as;
  ev_t        mon_e;
  initial forever begin
    @(negedge clk);
    if (m_on) begin
      mon_es = (sb.size() > 0 && sb[0].cyc == cyc) ? sb[0].s : 4'b0000;
      mon_as = {done1, done0, gnt1, gnt0};
      chk("strobes", int'(mon_as), int'(mon_es));
      if (mon_es != 4'b0000) begin
        mon_e = sb.pop_front();
        if (mon_es[1:0] != 2'b00) begin
          glog.push_back(int'(mon_es[1]));
          chk("gnt_ci1", int'(ci1), int'(mon_e.v1));
          chk("gnt_ci2", int'(ci2), int'(mon_e.v2));
        end else begin
          chk("done_result", int'(mon_es[3] ? result1 : result0), int'(mon_e.v1));
        end
      end
      chk("busy", int'(busy), int'(!m_idle));
      chk("ci1", int'(ci1), int'(m_ci1));
      chk("ci2", int'(ci2), int'(m_ci2));
      chk("result0", int'(result0), int'(m_res0));
      chk("result1", int'(result1), int'(m_res1));
    end
  end
  initial forever begin
    @(negedge clk);
    cmp_out = 8'($urandom);
  end
  bit drop0 = 1, drop1 = 1;
  int busy_cycles = 0;
  task automatic tick();
    @(negedge clk);
    if (gnt0 && drop0) begin req0 = 0; a0 = 8'($urandom); b0 = 8'($urandom); end
    if (gnt1 && drop1) begin req1 = 0; a1 = 8'($urandom); b1 = 8'($urandom); end
  endtask
  task automatic wait_idle();
    int n = 0;
    busy_cycles = 0;
    do begin
      tick();
      n++;
      if (busy) busy_cycles++;
    end while ((busy || req0 || req1 || sb.size() != 0) && n < 200);
    if (n >= 200) chk("idle_timeout", 1, 0);
  endtask
  initial begin
    repeat (2) tick();
    reset = 0;
    glog.delete();
    a0 = 8'd2; b0 = 8'd8; a1 = 8'd8; b1 = 8'd2; req0 = 1; req1 = 1;
    wait_idle();
    chk("tie_count", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("tie_first", glog[0], 0);
      chk("tie_second", glog[1], 1);
    end
    glog.delete();
    a0 = 8'd1; b0 = 8'd0; req0 = 1;
    wait_idle();
    chk("single_count", glog.size(), 1);
    chk("single_ci1", int'(ci1), 1);
    chk("single_ci2", int'(ci2), 0);
    glog.delete();
    drop0 = 0; drop1 = 0;
    a0 = 8'd17; b0 = 8'd34; a1 = 8'd51; b1 = 8'd68; req0 = 1; req1 = 1;
    repeat (6 * (SETTLE + 1)) tick();
    req0 = 0; req1 = 0; drop0 = 1; drop1 = 1;
    wait_idle();
    chk("hold_grants", glog.size(), 6);
    if (glog.size() == 6)
      for (int i = 1; i < 6; i++) chk("alternate", glog[i], 1 - glog[i-1]);
    glog.delete();
    a1 = 8'd5; b1 = 8'd5; req1 = 1;
    wait_idle();
    chk("busy_len", busy_cycles, SETTLE);
    chk("settle_count", glog.size(), 1);
    begin
      int n = 0;
      a1 = 8'd9; b1 = 8'd3; req1 = 1;
      do begin tick(); n++; end while (!busy && n < 20);
      chk("mid_busy", int'(busy), 1);
      tick();
      reset = 1;
      tick();
      reset = 0;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done1", int'(done1), 0);
      chk("rst_ci1", int'(ci1), 0);
      chk("rst_result1", int'(result1), 0);
    end
    glog.delete();
    a0 = 8'd7; b0 = 8'd6; a1 = 8'd4; b1 = 8'd3; req0 = 1; req1 = 1;
    wait_idle();
    chk("post_rst_count", glog.size(), 2);
    if (glog.size() == 2) chk("post_rst_first", glog[0], 0);
    glog.delete();
    begin
      int n = 0;
      a1 = 8'h33; b1 = 8'h44; req1 = 1;
      do begin tick(); n++; end while (!busy && n < 20);
      a0 = 8'h99; b0 = 8'h88; req0 = 1;
      tick();
      req0 = 0;
      wait_idle();
      chk("pulse_count", glog.size(), 1);
      if (glog.size() == 1) chk("pulse_port", glog[0], 1);
      chk("pulse_ci1", int'(ci1), 'h33);
      chk("pulse_ci2", int'(ci2), 'h44);
    end
    repeat (1500) begin
      tick();
      if (!req0) begin
        if ($urandom % 3 == 0) begin req0 = 1; a0 = 8'($urandom); b0 = 8'($urandom); end
      end else if ($urandom % 16 == 0) req0 = 0;
      if (!req1) begin
        if ($urandom % 3 == 0) begin req1 = 1; a1 = 8'($urandom); b1 = 8'($urandom); end
      end else if ($urandom % 16 == 0) req1 = 0;
    end
    req0 = 0; req1 = 0;
    wait_idle();
    chk("queue_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
